// File: rtl/rv32_shift_issue_stage_if.sv
// Issue-side and writeback-side handshake bundle for rv32_shift_issue_stage.
// The stage is the slave: it consumes instructions and produces results.
interface rv32_shift_issue_stage_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_rd;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_instr, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_tag, out_illegal
  );
endinterface

// File: rtl/rv32_shift_issue_stage.sv
// Two-stage issue/retire wrapper around an external RV32 barrel shifter (SLL/SRL/SRA + imm forms).
// Define SHIFT_ISSUE_ILLEGAL_EN to carry non-shift encodings to writeback flagged out_illegal.
module rv32_shift_issue_stage #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  rv32_shift_issue_stage_if.slave bus,
  output logic                 sh_enable,
  output logic                 sh_logical,
  output logic                 sh_direction,
  output logic                 sh_immediate,
  output logic [31:0]          sh_code_bus,
  output logic [31:0]          sh_rs1,
  output logic [31:0]          sh_rs2,
  input  logic [31:0]          sh_rd1,
  output logic [CNT_W-1:0]     shift_count
);

`ifdef SHIFT_ISSUE_ILLEGAL_EN
  localparam bit KEEP_ILLEGAL = 1'b1;
`else
  localparam bit KEEP_ILLEGAL = 1'b0;
`endif

  localparam int         STAGES = 2;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  typedef struct packed {
    logic [31:0]      instr;
    logic [31:0]      rs1;
    logic [4:0]       amt;
    logic [TAG_W-1:0] tag;
    logic             is_shift;
    logic             dir;
    logic             log_r;
    logic             imm;
  } s1_t;

  typedef struct packed {
    logic [31:0]      result;
    logic [4:0]       rd;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1, s1_d;
  s2_t             s2, s2_d;
  logic            s1_adv, s2_adv, accept, s2_load;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       dec_imm, dec_reg, dec_sll, dec_srl, dec_sra;

  // Only the low five bits of rs2 ever reach the shifter.
  logic unused_rs2;
  assign unused_rs2 = ^bus.in_rs2[31:5];

  always_comb begin
    opc     = bus.in_instr[6:0];
    f3      = bus.in_instr[14:12];
    f7      = bus.in_instr[31:25];
    dec_imm = (opc == OP_IMM);
    dec_reg = (opc == OP_REG);
    dec_sll = (dec_imm || dec_reg) && (f3 == 3'b001) && (f7 == 7'b0000000);
    dec_srl = (dec_imm || dec_reg) && (f3 == 3'b101) && (f7 == 7'b0000000);
    dec_sra = (dec_imm || dec_reg) && (f3 == 3'b101) && (f7 == 7'b0100000);

    s1_d          = '0;
    s1_d.instr    = bus.in_instr;
    s1_d.rs1      = bus.in_rs1;
    s1_d.amt      = bus.in_rs2[4:0];
    s1_d.tag      = bus.in_tag;
    s1_d.is_shift = dec_sll || dec_srl || dec_sra;
    s1_d.dir      = dec_srl || dec_sra;
    s1_d.log_r    = dec_srl;
    s1_d.imm      = dec_imm;
  end

  assign s2_adv      = !vld_pipe[2] || bus.out_ready;
  assign s1_adv      = vld_pipe[1] && s2_adv;
  assign bus.in_ready = !rst && !flush && (!vld_pipe[1] || s2_adv);
  assign accept      = bus.in_valid && bus.in_ready;

  // Non-shift entries only occupy S2 when they are to be reported as illegal.
  assign s2_load = s1.is_shift || KEEP_ILLEGAL;

  always_comb begin
    s2_d         = '0;
    s2_d.result  = s1.is_shift ? sh_rd1 : '0;
    s2_d.rd      = s1.instr[11:7];
    s2_d.tag     = s1.tag;
    s2_d.illegal = KEEP_ILLEGAL && !s1.is_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      s1          <= '0;
      s2          <= '0;
      shift_count <= '0;
    end else begin
      if (flush) begin
        vld_pipe <= '0;
      end else begin
        if (accept)      vld_pipe[1] <= 1'b1;
        else if (s1_adv) vld_pipe[1] <= 1'b0;
        if (s1_adv)             vld_pipe[2] <= s2_load;
        else if (bus.out_ready) vld_pipe[2] <= 1'b0;
      end
      if (accept) s1 <= s1_d;
      if (s1_adv) s2 <= s2_d;
      if (bus.out_valid && bus.out_ready && !s2.illegal && (shift_count != '1))
        shift_count <= shift_count + CNT_W'(1);
    end
  end

  // Controls are gated so the shifter sees all-zero when there is no shift to do.
  assign sh_enable    = vld_pipe[1] && s1.is_shift;
  assign sh_logical   = sh_enable && s1.log_r;
  assign sh_direction = sh_enable && s1.dir;
  assign sh_immediate = sh_enable && s1.imm;
  assign sh_code_bus  = s1.instr;
  assign sh_rs1       = s1.rs1;
  assign sh_rs2       = {27'b0, s1.amt};

  assign bus.out_valid   = vld_pipe[2];
  assign bus.out_result  = s2.result;
  assign bus.out_rd      = s2.rd;
  assign bus.out_tag     = s2.tag;
  assign bus.out_illegal = s2.illegal;

endmodule

// File: tb/tb_rv32_shift_issue_stage.sv
// Scoreboard bench for rv32_shift_issue_stage: reference model on instruction words, external shifter model,
// second instance with CNT_W=2 to exercise counter saturation.
module tb_rv32_shift_issue_stage;
  localparam int TAG_W = 4;

`ifdef SHIFT_ISSUE_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  rv32_shift_issue_stage_if #(.TAG_W(TAG_W)) ifc ();
  rv32_shift_issue_stage_if #(.TAG_W(TAG_W)) ifc2 ();

  logic        sh_en, sh_log, sh_dir, sh_imm;
  logic [31:0] sh_code, sh_rs1, sh_rs2, sh_rd1;
  logic [15:0] cnt;
  logic        sh_en_b, sh_log_b, sh_dir_b, sh_imm_b;
  logic [31:0] sh_code_b, sh_rs1_b, sh_rs2_b, sh_rd1_b;
  logic [1:0]  cnt_b;

  assign ifc2.in_valid  = ifc.in_valid;
  assign ifc2.in_instr  = ifc.in_instr;
  assign ifc2.in_rs1    = ifc.in_rs1;
  assign ifc2.in_rs2    = ifc.in_rs2;
  assign ifc2.in_tag    = ifc.in_tag;
  assign ifc2.out_ready = ifc.out_ready;

  rv32_shift_issue_stage #(.TAG_W(TAG_W), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(ifc.slave),
    .sh_enable(sh_en), .sh_logical(sh_log), .sh_direction(sh_dir), .sh_immediate(sh_imm),
    .sh_code_bus(sh_code), .sh_rs1(sh_rs1), .sh_rs2(sh_rs2), .sh_rd1(sh_rd1),
    .shift_count(cnt)
  );

  rv32_shift_issue_stage #(.TAG_W(TAG_W), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush), .bus(ifc2.slave),
    .sh_enable(sh_en_b), .sh_logical(sh_log_b), .sh_direction(sh_dir_b), .sh_immediate(sh_imm_b),
    .sh_code_bus(sh_code_b), .sh_rs1(sh_rs1_b), .sh_rs2(sh_rs2_b), .sh_rd1(sh_rd1_b),
    .shift_count(cnt_b)
  );

  // External combinational barrel shifter, driven by the stage's control outputs.
  function automatic logic [31:0] shifter(input logic en, lg, dir, imm,
                                          input logic [31:0] code, rs1, rs2);
    logic [4:0] a;
    if (!en) return 32'h0;
    a = imm ? code[24:20] : rs2[4:0];
    if (!dir) return rs1 << a;
    if (lg) return rs1 >> a;
    return 32'($signed(rs1) >>> a);
  endfunction

  always_comb sh_rd1   = shifter(sh_en, sh_log, sh_dir, sh_imm, sh_code, sh_rs1, sh_rs2);
  always_comb sh_rd1_b = shifter(sh_en_b, sh_log_b, sh_dir_b, sh_imm_b, sh_code_b, sh_rs1_b, sh_rs2_b);

  typedef struct packed {
    logic [31:0]      result;
    logic [4:0]       rd;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errs = 0;
  int   model_cnt = 0;
  int   rmode = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Architectural meaning of an instruction word; returns 1 if writeback should see an entry.
  function automatic bit ref_model(input logic [31:0] ins, rs1, rs2, input logic [TAG_W-1:0] tag,
                                   output exp_t e);
    bit is_i, is_r, ok;
    int amt;
    is_i = (ins[6:0] == 7'h13);
    is_r = (ins[6:0] == 7'h33);
    amt  = is_i ? int'(ins[24:20]) : int'(rs2 % 32);
    e = '0;
    e.rd  = ins[11:7];
    e.tag = tag;
    ok = 1'b0;
    if (is_i || is_r) begin
      ok = 1'b1;
      case ({ins[31:25], ins[14:12]})
        {7'h00, 3'd1}: e.result = rs1 << amt;
        {7'h00, 3'd5}: e.result = rs1 >> amt;
        {7'h20, 3'd5}: e.result = (rs1 >> amt) | (rs1[31] ? ~(32'hFFFF_FFFF >> amt) : 32'h0);
        default:       ok = 1'b0;
      endcase
    end
    if (!ok) begin
      e.result  = 32'h0;
      e.illegal = 1'b1;
      return ILL_EN;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] mk(input int kind, input bit imm, input logic [4:0] rd, rs1f, sh);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = (kind == 2) ? 7'h20 : 7'h00;
    f3 = (kind == 0) ? 3'd1 : 3'd5;
    return {f7, sh, rs1f, f3, rd, imm ? 7'h13 : 7'h33};
  endfunction

  // Monitor: retire-side checking against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errs++;
        $display("FAIL spurious_out: got out_valid with result %h, expected no entry", ifc.out_result);
      end else begin
        e = sb.pop_front();
        chk("out_result", ifc.out_result, e.result);
        chk("out_rd", 32'(ifc.out_rd), 32'(e.rd));
        chk("out_tag", 32'(ifc.out_tag), 32'(e.tag));
        chk("out_illegal", 32'(ifc.out_illegal), 32'(e.illegal));
        if (!e.illegal) model_cnt++;
      end
    end
    if (!rst && sh_en) chk("sh_rs2_hi", 32'(sh_rs2[31:5]), 32'h0);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rmode == 1) ifc.out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [31:0] ins, rs1, rs2, input logic [TAG_W-1:0] tag);
    exp_t e;
    int   n;
    ifc.in_instr = ins;
    ifc.in_rs1   = rs1;
    ifc.in_rs2   = rs2;
    ifc.in_tag   = tag;
    ifc.in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (ifc.in_ready) begin
        if (ref_model(ins, rs1, rs2, tag, e)) sb.push_back(e);
        tick(1);
        break;
      end
      n++;
      if (n > 200) begin
        vectors++;
        errs++;
        $display("FAIL accept_timeout: got in_ready low for %0d cycles, expected accept", n);
        tick(1);
        break;
      end
      tick(1);
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'h0);
    tick(2);
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_count"}, 32'(cnt), 32'(model_cnt));
    chk({nm, "_count_sat"}, 32'(cnt_b), 32'((model_cnt > 3) ? 3 : model_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected finish");
    errs++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, ins, rs1v, rs2v;
    int          r;

    ifc.in_valid = 1'b1;
    ifc.in_instr = 32'h00409293;
    ifc.in_rs1 = 32'h0;
    ifc.in_rs2 = 32'h0;
    ifc.in_tag = '0;
    ifc.out_ready = 1'b1;
    tick(3);
    chk("rst_in_ready", 32'(ifc.in_ready), 32'h0);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("rst_out_result", ifc.out_result, 32'h0);
    chk("rst_sh_enable", 32'(sh_en), 32'h0);
    chk_counts("rst");
    ifc.in_valid = 1'b0;
    rst = 1'b0;
    tick(1);

    // SLLI x5,x1,4: two-cycle latency
    drive(32'h00409293, 32'h0000_00F1, 32'h0, 4'h1);
    chk("slli_lat1", 32'(ifc.out_valid), 32'h0);
    chk("slli_sh_imm", 32'(sh_imm), 32'h1);
    chk("slli_sh_dir", 32'(sh_dir), 32'h0);
    tick(1);
    chk("slli_lat2", 32'(ifc.out_valid), 32'h1);
    chk("slli_result", ifc.out_result, 32'h0000_0F10);
    chk("slli_rd", 32'(ifc.out_rd), 32'h5);

    // SRA x3,x1,x2 with rs2 upper bits set
    drive(32'h4020D1B3, 32'h8000_0000, 32'hFFFF_FFE4, 4'h2);
    chk("sra_sh_rs2", sh_rs2, 32'h4);
    chk("sra_sh_enable", 32'(sh_en), 32'h1);
    chk("sra_sh_dir", 32'(sh_dir), 32'h1);
    chk("sra_sh_log", 32'(sh_log), 32'h0);
    tick(1);
    chk("sra_result", ifc.out_result, 32'hF800_0000);
    drain();
    chk_counts("directed");

    // Back-to-back with writeback stalled
    ifc.out_ready = 1'b0;
    drive(mk(1, 1'b0, 5'd6, 5'd1, 5'd2), 32'hF0F0_0000, 32'h0000_0008, 4'h3);
    drive(mk(2, 1'b0, 5'd7, 5'd1, 5'd2), 32'h8000_00F0, 32'h0000_0021, 4'h4);
    chk("stall_in_ready", 32'(ifc.in_ready), 32'h0);
    chk("stall_valid", 32'(ifc.out_valid), 32'h1);
    r0 = ifc.out_result;
    chk("stall_first", r0, 32'h00F0_F000);
    tick(3);
    chk("stall_hold_result", ifc.out_result, r0);
    chk("stall_hold_valid", 32'(ifc.out_valid), 32'h1);
    chk("stall_hold_ready", 32'(ifc.in_ready), 32'h0);
    ifc.out_ready = 1'b1;
    drive(mk(0, 1'b1, 5'd8, 5'd1, 5'd3), 32'h1, 32'h0, 4'h5);
    drain();
    chk_counts("stall");

    // Non-shift encoding (ADD)
    drive(32'h002081B3, 32'h5, 32'h6, 4'h6);
    tick(1);
    if (ILL_EN) begin
      chk("add_valid", 32'(ifc.out_valid), 32'h1);
      chk("add_illegal", 32'(ifc.out_illegal), 32'h1);
      chk("add_result", ifc.out_result, 32'h0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk("add_no_out", 32'(ifc.out_valid), 32'h0);
        tick(1);
      end
    end
    drain();
    chk_counts("add");

    // Flush with S2 stalled and S1 full
    ifc.out_ready = 1'b0;
    drive(mk(0, 1'b1, 5'd9, 5'd2, 5'd1), 32'h3, 32'h0, 4'h7);
    drive(mk(1, 1'b1, 5'd10, 5'd2, 5'd1), 32'h3, 32'h0, 4'h8);
    flush = 1'b1;
    ifc.in_instr = mk(0, 1'b1, 5'd11, 5'd2, 5'd1);
    ifc.in_valid = 1'b1;
    #1;
    chk("flush_in_ready", 32'(ifc.in_ready), 32'h0);
    sb.delete();
    @(posedge clk);
    #1;
    flush = 1'b0;
    ifc.in_valid = 1'b0;
    chk("flush_out_valid", 32'(ifc.out_valid), 32'h0);
    chk("flush_sh_enable", 32'(sh_en), 32'h0);
    ifc.out_ready = 1'b1;
    tick(3);
    chk("flush_out_valid_later", 32'(ifc.out_valid), 32'h0);
    chk_counts("flush");

    // Randomized traffic with random writeback backpressure
    rmode = 1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      rs1v = $urandom;
      rs2v = $urandom;
      if (r == 0) ins = $urandom;
      else if (r == 1) ins = mk($urandom_range(0, 2), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)) | 32'h0200_0000;
      else if (r == 2) ins = mk($urandom_range(0, 2), 1'($urandom), 5'($urandom), 5'($urandom), 5'd31);
      else ins = mk($urandom_range(0, 2), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
      if (r == 3) rs2v = 32'hFFFF_FFE0;
      drive(ins, rs1v, rs2v, TAG_W'($urandom));
      if ($urandom_range(0, 4) == 0) tick(1);
    end
    rmode = 0;
    ifc.out_ready = 1'b1;
    drain();
    chk_counts("random");

    // Reset with entries in flight
    ifc.out_ready = 1'b0;
    drive(mk(2, 1'b1, 5'd12, 5'd3, 5'd7), 32'h8765_4321, 32'h0, 4'h9);
    drive(mk(1, 1'b0, 5'd13, 5'd3, 5'd4), 32'h8765_4321, 32'h3, 4'hA);
    rst = 1'b1;
    sb.delete();
    model_cnt = 0;
    tick(1);
    rst = 1'b0;
    chk("rstmid_out_valid", 32'(ifc.out_valid), 32'h0);
    chk_counts("rstmid");
    ifc.out_ready = 1'b1;
    tick(3);
    chk("rstmid_out_valid_later", 32'(ifc.out_valid), 32'h0);
    drive(32'h00409293, 32'h0000_0001, 32'h0, 4'hB);
    drain();
    chk_counts("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
